// File: rtl/codec_unit_pkg.sv
// Shared I2S codec constants, status bits and frame helpers.
package codec_unit_pkg;

  localparam int I2S_SAMPLE_WIDTH = 24;
  localparam int I2S_SLOT_WIDTH   = 32;
  localparam int I2S_FIFO_DEPTH   = 16;
  localparam int I2S_BCLK_DIV     = 4;

  // Sticky status bits, also mirrored by register_unit.
  typedef struct packed {
    logic underrun;
    logic overflow;
  } i2s_status_t;

  // WCLK is high for periods [slot-1, 2*slot-2]: it leads each slot MSB by one BCLK.
  // Written without subtraction so the unsigned compare cannot wrap.
  function automatic logic wclk_high(input int unsigned p, input int unsigned slot);
    return ((p + 1) >= slot) && ((p + 2) <= (2 * slot));
  endfunction

endpackage

// File: rtl/i2s_stream_tx_if.sv
// Sample-write path: stereo word push strobe plus FIFO fill feedback.
interface i2s_stream_tx_if
  import codec_unit_pkg::*;
#(
  parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
  parameter int FIFO_DEPTH   = I2S_FIFO_DEPTH
) ();

  logic [2*SAMPLE_WIDTH-1:0]   sample_in;   // {left, right}
  logic                        sample_wr;
  logic                        fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  modport master (output sample_in, output sample_wr, input fifo_full, input fifo_level);
  modport slave  (input sample_in, input sample_wr, output fifo_full, output fifo_level);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered level/full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  // A push while full is refused even if a pop frees a slot this cycle.
  assign do_push  = push & ~full_q;
  assign do_pop   = pop & (level_q != '0);
  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = (level_q == '0);
  assign level    = level_q;

  // Pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d = (level_d == LVL_FULL);
  end

  // Control state; contents are discarded by resetting the pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/i2s_stream_tx.sv
// Philips I2S transmitter: BCLK divider, period counter, frame shift register,
// sticky underrun/overflow, fed from an on-chip stereo sample FIFO.
module i2s_stream_tx
  import codec_unit_pkg::*;
#(
  parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH,
  parameter int FIFO_DEPTH   = I2S_FIFO_DEPTH,
  parameter int BCLK_DIV     = I2S_BCLK_DIV
) (
  input  logic           board_clk,
  input  logic           reset,
  i2s_stream_tx_if.slave wr,
  input  logic           enable,
  input  logic           mono_mode,
  input  logic           clear_status,
  output logic           underrun,
  output logic           overflow,
  output logic           i2s_bclk,
  output logic           i2s_wclk,
  output logic           i2s_data
);

  localparam int FRAME = 2 * SLOT_WIDTH;
  localparam int PW    = $clog2(FRAME);
  localparam int CW    = $clog2(BCLK_DIV);
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(BCLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BCLK_DIV / 2);
  localparam logic [PW-1:0] P_LAST   = PW'(FRAME - 1);

  // FIFO side
  logic [2*SAMPLE_WIDTH-1:0] fifo_rd_data;
  logic                      fifo_empty, fifo_full, fifo_pop;
  logic [LW-1:0]             fifo_level;

  // Sequencer state
  logic             run_q, run_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;
  logic [FRAME-1:0] sh_q, sh_d;
  logic             bclk_q, bclk_d;
  logic             wclk_q, wclk_d;
  logic             data_q, data_d;
  i2s_status_t      status_q, status_d;

  logic                    frame_load;
  logic [FRAME-1:0]        frame_word, cur_frame;
  logic [SAMPLE_WIDTH-1:0] left_smp, right_smp;

  sync_fifo #(
    .WIDTH (2 * SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (board_clk),
    .rst       (reset),
    .push      (wr.sample_wr),
    .push_data (wr.sample_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign wr.fifo_full  = fifo_full;
  assign wr.fifo_level = fifo_level;

  assign left_smp  = fifo_rd_data[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
  assign right_smp = mono_mode ? left_smp : fifo_rd_data[SAMPLE_WIDTH-1:0];

  // Whole-frame image of the head word, MSB-justified in each slot; zero on underrun.
  always_comb begin
    frame_word = '0;
    if (!fifo_empty) begin
      frame_word[FRAME-1 -: SAMPLE_WIDTH]      = left_smp;
      frame_word[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = right_smp;
    end
  end

  // Divider / period counter / shifter. Outputs only move at the start of a
  // BCLK period; the first cycle after enable rises is already a period start.
  always_comb begin
    run_d      = run_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    sh_d       = sh_q;
    bclk_d     = bclk_q;
    wclk_d     = wclk_q;
    data_d     = data_q;
    cur_frame  = sh_q;
    frame_load = 1'b0;
    if (!enable) begin
      run_d  = 1'b0;
      cnt_d  = '0;
      p_d    = P_LAST;
      sh_d   = '0;
      bclk_d = 1'b0;
      wclk_d = 1'b0;
      data_d = 1'b0;
    end else begin
      run_d = 1'b1;
      if (!run_q || cnt_q == CNT_LAST) begin
        cnt_d      = '0;
        p_d        = (!run_q || p_q == P_LAST) ? '0 : p_q + 1'b1;
        frame_load = (p_d == '0);
        cur_frame  = frame_load ? frame_word : sh_q;
        data_d     = cur_frame[FRAME-1];
        sh_d       = cur_frame << 1;
        wclk_d     = wclk_high(32'(p_d), SLOT_WIDTH);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      bclk_d = (cnt_d >= CNT_HALF);
    end
  end

  assign fifo_pop = frame_load & ~fifo_empty;

  // Sticky status; a set in the same cycle as clear wins.
  always_comb begin
    status_d = status_q;
    if (clear_status) status_d = '0;
    if (frame_load && fifo_empty)   status_d.underrun = 1'b1;
    if (wr.sample_wr && fifo_full)  status_d.overflow = 1'b1;
  end

  // State registers.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      p_q      <= '0;
      sh_q     <= '0;
      bclk_q   <= 1'b0;
      wclk_q   <= 1'b0;
      data_q   <= 1'b0;
      status_q <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      sh_q     <= sh_d;
      bclk_q   <= bclk_d;
      wclk_q   <= wclk_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  assign i2s_bclk = bclk_q;
  assign i2s_wclk = wclk_q;
  assign i2s_data = data_q;
  assign underrun = status_q.underrun;
  assign overflow = status_q.overflow;

endmodule

// File: tb/tb_i2s_stream_tx.sv
// Directed + random bench for i2s_stream_tx against a frame-level reference model.
module tb_i2s_stream_tx;

  localparam int W         = 24;
  localparam int S         = 32;
  localparam int DEPTH     = 16;
  localparam int DIV       = 4;
  localparam int FRAME_CYC = 2 * S * DIV;

  logic board_clk, reset, enable, mono_mode, clear_status;
  logic underrun, overflow, i2s_bclk, i2s_wclk, i2s_data;

  i2s_stream_tx_if #(.SAMPLE_WIDTH(W), .FIFO_DEPTH(DEPTH)) wr_if ();

  i2s_stream_tx #(
    .SAMPLE_WIDTH (W),
    .SLOT_WIDTH   (S),
    .FIFO_DEPTH   (DEPTH),
    .BCLK_DIV     (DIV)
  ) dut (
    .board_clk    (board_clk),
    .reset        (reset),
    .wr           (wr_if),
    .enable       (enable),
    .mono_mode    (mono_mode),
    .clear_status (clear_status),
    .underrun     (underrun),
    .overflow     (overflow),
    .i2s_bclk     (i2s_bclk),
    .i2s_wclk     (i2s_wclk),
    .i2s_data     (i2s_data)
  );

  initial begin
    board_clk = 1'b0;
    forever #5 board_clk = ~board_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not reach its end");
    $fatal(1, "timeout");
  end

  int total = 0;
  int bad   = 0;

  // Reference model: queue of accepted words plus expected sticky flags.
  logic [2*W-1:0] q[$];
  bit             exp_und, exp_ovf;

  logic [W-1:0]   l, r;
  logic [2*W-1:0] w, wa, wb;

  task automatic tick();
    @(posedge board_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] rnd48();
    logic [2*W-1:0] v;
    v[2*W-1:W] = W'($urandom);
    v[W-1:0]   = W'($urandom);
    return v;
  endfunction

  // Line bit for period p of a frame carrying (left, right).
  function automatic logic exp_bit(input logic [W-1:0] lv, input logic [W-1:0] rv, input int p);
    if (p < W) return lv[W-1-p];
    if (p >= S && p < S + W) return rv[W-1-(p-S)];
    return 1'b0;
  endfunction

  task automatic push_word(input logic [2*W-1:0] d);
    wr_if.sample_in = d;
    wr_if.sample_wr = 1'b1;
    tick();
    wr_if.sample_wr = 1'b0;
    if (q.size() >= DEPTH) exp_ovf = 1'b1;
    else q.push_back(d);
  endtask

  // Frame load in the model: occupancy seen by a same-edge push is the pre-pop one.
  task automatic model_load(input bit do_push, input logic [2*W-1:0] pw,
                            output logic [W-1:0] lo, output logic [W-1:0] ro);
    logic [2*W-1:0] h;
    bit was_full;
    was_full = (q.size() >= DEPTH);
    if (q.size() == 0) begin
      lo = '0; ro = '0; exp_und = 1'b1;
    end else begin
      h  = q.pop_front();
      lo = h[2*W-1:W];
      ro = mono_mode ? h[2*W-1:W] : h[W-1:0];
    end
    if (do_push) begin
      if (was_full) exp_ovf = 1'b1;
      else q.push_back(pw);
    end
  endtask

  // Called at the first cycle of a frame; ends at the first cycle of the next
  // frame (or the first idle cycle when last=1).
  task automatic run_frame(input string tag, input logic [W-1:0] lv, input logic [W-1:0] rv,
                           input bit last, input bit do_push, input logic [2*W-1:0] pw,
                           input bit mono_next);
    logic [63:0] od, ed, ow, ew;
    int p, k, bclk_bad, hold_bad;
    od = '0; ow = '0; ed = '0; ew = '0; bclk_bad = 0; hold_bad = 0;
    for (int i = 0; i < 2*S; i++) begin
      ed[63-i] = exp_bit(lv, rv, i);
      ew[63-i] = (i >= S-1) && (i <= 2*S-2);
    end
    for (int c = 0; c < FRAME_CYC; c++) begin
      p = c / DIV;
      k = c % DIV;
      @(negedge board_clk);
      if (c == 0) begin
        chk({tag, "_level"}, 64'(wr_if.fifo_level), 64'(q.size()));
        chk({tag, "_full"},  64'(wr_if.fifo_full),  64'(q.size() == DEPTH));
      end
      if (k == 0) begin
        od[63-p] = i2s_data;
        ow[63-p] = i2s_wclk;
      end else if (i2s_data !== od[63-p] || i2s_wclk !== ow[63-p]) begin
        hold_bad++;
      end
      if (i2s_bclk !== (k >= DIV/2)) bclk_bad++;
      if (c == 100) mono_mode = mono_next;
      if (c == FRAME_CYC-1) begin
        if (last) enable = 1'b0;
        else if (do_push) begin
          wr_if.sample_in = pw;
          wr_if.sample_wr = 1'b1;
        end
      end
      tick();
      wr_if.sample_wr = 1'b0;
    end
    chk({tag, "_data"},     od, ed);
    chk({tag, "_wclk"},     ow, ew);
    chk({tag, "_bclk_bad"}, 64'(bclk_bad), 64'(0));
    chk({tag, "_hold_bad"}, 64'(hold_bad), 64'(0));
  endtask

  task automatic chk_status(input string tag);
    @(negedge board_clk);
    chk({tag, "_underrun"}, 64'(underrun), 64'(exp_und));
    chk({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
    tick();
  endtask

  task automatic chk_level(input string tag);
    @(negedge board_clk);
    chk({tag, "_level"}, 64'(wr_if.fifo_level), 64'(q.size()));
    chk({tag, "_full"},  64'(wr_if.fifo_full),  64'(q.size() == DEPTH));
    tick();
  endtask

  task automatic chk_idle(input string tag);
    @(negedge board_clk);
    chk({tag, "_bclk"}, 64'(i2s_bclk), 64'(0));
    chk({tag, "_wclk"}, 64'(i2s_wclk), 64'(0));
    chk({tag, "_data"}, 64'(i2s_data), 64'(0));
    tick();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mono_mode = 1'b0; clear_status = 1'b0;
    wr_if.sample_in = '0; wr_if.sample_wr = 1'b0;
    exp_und = 1'b0; exp_ovf = 1'b0;

    // Reset state
    repeat (3) @(posedge board_clk);
    chk_idle("rst");
    chk_level("rst");
    chk_status("rst");
    reset = 1'b0;
    tick();

    // 1: single stereo word
    push_word({24'hA5A5A5, 24'h3C3C3C});
    chk_level("t1_push");
    enable = 1'b1; tick(); model_load(1'b0, '0, l, r);
    run_frame("t1", l, r, 1'b1, 1'b0, '0, 1'b0);
    chk_idle("t1_idle");
    chk_status("t1");

    // 2: mono; flipping mono mid-frame must not touch the current frame
    mono_mode = 1'b1;
    push_word({24'h800001, 24'hFFFFFF});
    enable = 1'b1; tick(); model_load(1'b0, '0, l, r);
    run_frame("t2", l, r, 1'b1, 1'b0, '0, 1'b0);
    chk_status("t2");

    // 3: empty FIFO, clear, clear colliding with a set
    enable = 1'b1; tick(); model_load(1'b0, '0, l, r);
    run_frame("t3a", l, r, 1'b1, 1'b0, '0, 1'b0);
    chk_status("t3_set");
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    exp_und = 1'b0; exp_ovf = 1'b0;
    chk_status("t3_clr");
    repeat (3) tick();
    chk_status("t3_hold");
    clear_status = 1'b1; enable = 1'b1; tick(); clear_status = 1'b0;
    exp_und = 1'b0; exp_ovf = 1'b0;
    model_load(1'b0, '0, l, r);
    run_frame("t3b", l, r, 1'b1, 1'b0, '0, 1'b0);
    chk_status("t3_win");

    // 4: overfill while idle, then drain past the end
    for (int i = 0; i < DEPTH; i++) push_word(rnd48());
    chk_level("t4_16");
    chk_status("t4_16");
    push_word(rnd48());
    chk_level("t4_17");
    chk_status("t4_17");
    enable = 1'b1; tick(); model_load(1'b0, '0, l, r);
    for (int f = 0; f < DEPTH + 1; f++) begin
      run_frame($sformatf("t4_f%0d", f), l, r, f == DEPTH, 1'b0, '0, 1'b0);
      if (f < DEPTH) model_load(1'b0, '0, l, r);
    end
    chk_status("t4_end");

    // 5: push/pop on the same edge at level 5, random data and mono
    for (int i = 0; i < 5; i++) push_word(rnd48());
    chk_level("t5_pre");
    w = rnd48();
    wr_if.sample_in = w; wr_if.sample_wr = 1'b1; enable = 1'b1;
    tick();
    wr_if.sample_wr = 1'b0;
    model_load(1'b1, w, l, r);
    for (int f = 0; f < 20; f++) begin
      w = rnd48();
      run_frame($sformatf("t5_f%0d", f), l, r, f == 19, f < 19, w, 1'($urandom));
      if (f < 19) model_load(1'b1, w, l, r);
    end
    mono_mode = 1'b0;
    chk_status("t5");

    // 6: asynchronous reset at p=40 with BCLK high
    enable = 1'b1; tick(); model_load(1'b0, '0, l, r);
    repeat (40*DIV + 2) @(posedge board_clk);
    #1;
    reset = 1'b1; enable = 1'b0;
    #1;
    q.delete(); exp_und = 1'b0; exp_ovf = 1'b0;
    chk("t6_rst_bclk",  64'(i2s_bclk),         64'(0));
    chk("t6_rst_wclk",  64'(i2s_wclk),         64'(0));
    chk("t6_rst_data",  64'(i2s_data),         64'(0));
    chk("t6_rst_level", 64'(wr_if.fifo_level), 64'(q.size()));
    chk("t6_rst_und",   64'(underrun),         64'(exp_und));
    chk("t6_rst_ovf",   64'(overflow),         64'(exp_ovf));
    repeat (2) @(posedge board_clk);
    #1;
    reset = 1'b0;
    tick();

    // 6b: abandon a frame mid-way, then restart cleanly
    wa = rnd48(); wb = rnd48();
    push_word(wa);
    push_word(wb);
    enable = 1'b1; tick(); model_load(1'b0, '0, l, r);
    repeat (100) @(posedge board_clk);
    #1;
    enable = 1'b0;
    tick();
    chk_level("t6_abandon");
    chk_idle("t6_abandon");
    enable = 1'b1; tick(); model_load(1'b0, '0, l, r);
    run_frame("t6_restart", l, r, 1'b1, 1'b0, '0, 1'b0);
    chk_status("t6_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
